// File: rtl/xc_rf_1.sv
// xc_rf_1: multi-ported integer register file with pair writes and post-reset scrub.
//
// Parameters:
//   XLEN   register width in bits
//   NREGS  register count (power of two, >= 4); AW = log2(NREGS)
//   BYPASS 1: same-cycle write data is forwarded to the read ports
//   SCRUB  1: registers 1..NREGS-1 are zeroed one per cycle after reset
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   rs1/rs2/rs3_addr -> _rdata    three independent combinational read ports
//   rd_wen, rd_wide, rd_addr      write enable, pair-write select, write address
//   rd_wdata, rd_wdata_hi         data for rd_addr and rd_addr+1 (pair write)
//   busy                          scrub in progress (reads 0, writes ignored)
//   wr_err                        registered: odd-address pair write or write while busy
module xc_rf_1 #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned SCRUB  = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rs3_addr,
    output logic [XLEN-1:0] rs1_rdata,
    output logic [XLEN-1:0] rs2_rdata,
    output logic [XLEN-1:0] rs3_rdata,
    input  logic            rd_wen,
    input  logic            rd_wide,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic [XLEN-1:0] rd_wdata_hi,
    output logic            busy,
    output logic            wr_err
);

    typedef enum logic [0:0] {StIdle, StScrub} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;
    logic            wr_err_q;

    // Entry 0 is never written; reads of address 0 are forced to zero.
    logic [XLEN-1:0] regs_q [NREGS];

    logic            wide_odd;
    logic            wr_ok;
    logic            wr_lo_en;
    logic            wr_hi_en;
    logic [AW-1:0]   hi_addr;

    logic [AW-1:0]   rs_addr  [3];
    logic [XLEN-1:0] rs_rdata [3];

    assign busy   = busy_q;
    assign wr_err = wr_err_q;

    // Write qualification: writes are dropped during reset and scrub; an odd
    // pair write touches nothing; the low half of a pair at address 0 is dropped.
    always_comb begin
        wide_odd = rd_wide && rd_addr[0];
        wr_ok    = rd_wen && !reset && !busy_q;
        wr_lo_en = wr_ok && !wide_odd && (rd_addr != '0);
        wr_hi_en = wr_ok && rd_wide && !rd_addr[0];
        hi_addr  = {rd_addr[AW-1:1], 1'b1};
    end

    // Scrub FSM and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= (SCRUB != 0) ? StScrub : StIdle;
            cnt_q    <= AW'(1);
            busy_q   <= (SCRUB != 0);
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= rd_wen && (busy_q || wide_odd);
            if (state_q == StScrub) begin
                cnt_q <= cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    // Register array: not reset; cleared only by the scrub sweep.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == StScrub)) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (wr_lo_en) begin
                regs_q[rd_addr] <= rd_wdata;
            end
            if (wr_hi_en) begin
                regs_q[hi_addr] <= rd_wdata_hi;
            end
        end
    end

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;
    assign rs_addr[2] = rs3_addr;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rs_rdata[i] = '0;
            if (!busy_q && (rs_addr[i] != '0)) begin
                rs_rdata[i] = regs_q[rs_addr[i]];
                if (BYPASS != 0) begin
                    if (wr_lo_en && (rs_addr[i] == rd_addr)) begin
                        rs_rdata[i] = rd_wdata;
                    end
                    if (wr_hi_en && (rs_addr[i] == hi_addr)) begin
                        rs_rdata[i] = rd_wdata_hi;
                    end
                end
            end
        end
    end

    assign rs1_rdata = rs_rdata[0];
    assign rs2_rdata = rs_rdata[1];
    assign rs3_rdata = rs_rdata[2];

endmodule
